// File: rtl/fpu_muldiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle half-precision mul/div unit
// between two requesters, with operand hold, start pulse and watchdog.
module fpu_muldiv_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  op,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_ofuf,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] unit_x,
    output logic [15:0] unit_y,
    output logic        unit_muldiv,
    output logic        unit_start,
    input  logic        unit_done,
    input  logic [15:0] unit_result,
    input  logic [1:0]  unit_ofuf
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             last;
    logic             win;
    logic [CNT_W-1:0] wd;
    logic             wd_expired;

    assign wd_expired = (wd == CNT_W'(TIMEOUT - 1));

    // A tie goes to the requester that was not served last.
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (unit_done || wd_expired) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are registered by decoding the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt        <= '0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
            unit_start <= 1'b0;
        end else begin
            gnt        <= (state_n == START) ? {win, ~win} : '0;
            unit_start <= (state_n == START);
            busy       <= (state_n != IDLE);
            rsp_valid  <= (state_n == RESP) ? {last, ~last} : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last        <= 1'b1;
            unit_x      <= '0;
            unit_y      <= '0;
            unit_muldiv <= 1'b0;
            rsp_result  <= '0;
            rsp_ofuf    <= '0;
            rsp_timeout <= 1'b0;
            wd          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        last        <= win;
                        unit_x      <= win ? x_in[31:16] : x_in[15:0];
                        unit_y      <= win ? y_in[31:16] : y_in[15:0];
                        unit_muldiv <= op[win];
                    end
                end
                START: begin
                    wd <= '0;
                end
                WAIT: begin
                    // Done wins over a watchdog expiry in the same cycle.
                    if (unit_done) begin
                        rsp_result  <= unit_result;
                        rsp_ofuf    <= unit_ofuf;
                        rsp_timeout <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_result  <= '0;
                        rsp_ofuf    <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_muldiv_arbiter.sv
// Self-checking bench for fpu_muldiv_arbiter: directed scenarios plus random
// transactions against a transaction-level arbitration/latency model.
module tb_fpu_muldiv_arbiter;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_ofuf;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] unit_x;
    logic [15:0] unit_y;
    logic        unit_muldiv;
    logic        unit_start;
    logic        unit_done   = 1'b0;
    logic [15:0] unit_result = 16'h0;
    logic [1:0]  unit_ofuf   = 2'b00;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned m_last   = 1;

    // Behavioural unit: after sampling start, done rises u_lat+1 cycles into
    // WAIT and then stays high until the next start.
    int unsigned u_lat   = 1;
    bit          u_never = 1'b0;
    logic [15:0] u_res   = 16'h0;
    logic [1:0]  u_of    = 2'b00;
    int unsigned ucnt    = 0;

    fpu_muldiv_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .op          (op),
        .x_in        (x_in),
        .y_in        (y_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_ofuf    (rsp_ofuf),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .unit_x      (unit_x),
        .unit_y      (unit_y),
        .unit_muldiv (unit_muldiv),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .unit_ofuf   (unit_ofuf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (unit_start) begin
            ucnt      <= u_never ? 0 : u_lat;
            unit_done <= 1'b0;
        end else if (ucnt > 1) begin
            ucnt <= ucnt - 1;
        end else if (ucnt == 1) begin
            ucnt        <= 0;
            unit_done   <= 1'b1;
            unit_result <= u_res;
            unit_ofuf   <= u_of;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt),        32'h0);
        check({tag, "_rspv"},  32'(rsp_valid),  32'h0);
        check({tag, "_res"},   32'(rsp_result), 32'h0);
        check({tag, "_ofuf"},  32'(rsp_ofuf),   32'h0);
        check({tag, "_tmo"},   32'(rsp_timeout),32'h0);
        check({tag, "_busy"},  32'(busy),       32'h0);
        check({tag, "_ux"},    32'(unit_x),     32'h0);
        check({tag, "_uy"},    32'(unit_y),     32'h0);
        check({tag, "_umd"},   32'(unit_muldiv),32'h0);
        check({tag, "_start"}, 32'(unit_start), 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_last = 1;
    endtask

    // One transaction: drive in IDLE, expect grant next cycle, then the
    // response after the unit's latency or the watchdog limit.
    task automatic do_op(input string tag, input logic [1:0] r, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input int unsigned lat, input bit never,
                         input logic [15:0] res, input logic [1:0] of);
        int unsigned w, n, didx;
        bit          tmo;
        logic [15:0] ex, ey;
        logic        eop;
        @(negedge clk);
        req = r; op = o; x_in = x; y_in = y;
        u_lat = lat; u_never = never; u_res = res; u_of = of;
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (m_last == 0) ? 1 : 0;
        m_last = w;
        ex  = (w == 1) ? x[31:16] : x[15:0];
        ey  = (w == 1) ? y[31:16] : y[15:0];
        eop = o[w];
        @(negedge clk);
        check({tag, "_gnt"},   32'(gnt),         32'(1) << w);
        check({tag, "_start"}, 32'(unit_start),  32'h1);
        check({tag, "_busy"},  32'(busy),        32'h1);
        check({tag, "_ux"},    32'(unit_x),      32'(ex));
        check({tag, "_uy"},    32'(unit_y),      32'(ey));
        check({tag, "_umd"},   32'(unit_muldiv), 32'(eop));
        check({tag, "_rspv_start"}, 32'(rsp_valid), 32'h0);
        x_in = $urandom; y_in = $urandom; op = 2'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, "_gnt_1cyc"},   32'(gnt),        32'h0);
                check({tag, "_start_1cyc"}, 32'(unit_start), 32'h0);
            end
        end while (rsp_valid == 2'b00 && n < 200);
        tmo  = never || (lat > TMO - 1);
        didx = tmo ? TMO - 1 : lat;
        check({tag, "_lat"},  32'(n),           32'(didx + 2));
        check({tag, "_rspv"}, 32'(rsp_valid),   32'(1) << w);
        check({tag, "_res"},  32'(rsp_result),  tmo ? 32'h0 : 32'(res));
        check({tag, "_ofuf"}, 32'(rsp_ofuf),    tmo ? 32'h0 : 32'(of));
        check({tag, "_tmo"},  32'(rsp_timeout), 32'(tmo));
        check({tag, "_uxh"},  32'(unit_x),      32'(ex));
        req = 2'b00;
        @(negedge clk);
        check({tag, "_rspv_1cyc"}, 32'(rsp_valid),  32'h0);
        check({tag, "_idle"},      32'(busy),       32'h0);
        check({tag, "_reshold"},   32'(rsp_result), tmo ? 32'h0 : 32'(res));
        check({tag, "_uyh"},       32'(unit_y),     32'(ey));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 2'b00; op = 2'b00; x_in = '0; y_in = '0;
        #3;
        check_all_zero("por");
        apply_reset();

        do_op("mul", 2'b01, 2'b00, 32'h0000_4F00, 32'h0000_0B80, 7, 1'b0, 16'h1E90, 2'b00);

        apply_reset();
        do_op("tie1", 2'b11, 2'b00, 32'hD98D_4F00, 32'h4F08_0B80, 7, 1'b0, 16'h1E90, 2'b00);
        do_op("tie2", 2'b11, 2'b00, 32'hD98D_4F00, 32'h4F08_0B80, 7, 1'b0, 16'hECE0, 2'b00);
        do_op("tie3", 2'b11, 2'b00, 32'hD98D_4F00, 32'h4F08_0B80, 7, 1'b0, 16'h1E90, 2'b00);

        do_op("stale", 2'b01, 2'b01, 32'h1111_3C00, 32'h2222_4000, 5, 1'b0, 16'h1234, 2'b01);

        do_op("tmo",   2'b10, 2'b10, 32'h4400_0000, 32'h0000_0000, 1, 1'b1, 16'hABCD, 2'b11);
        do_op("post",  2'b10, 2'b10, 32'h4400_0000, 32'h3C00_0000, 3, 1'b0, 16'h5555, 2'b10);

        do_op("coinc", 2'b01, 2'b00, 32'h0000_3C00, 32'h0000_3C00, TMO - 1, 1'b0, 16'h4321, 2'b11);

        // Reset three cycles into WAIT after serving requester 0.
        @(negedge clk);
        req = 2'b01; op = 2'b00; x_in = 32'h0000_4F00; y_in = 32'h0000_0B80;
        u_lat = 20; u_never = 1'b0; u_res = 16'h7777; u_of = 2'b00;
        @(negedge clk);
        check("rst_pre_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_rspv", 32'(rsp_valid), 32'h0);
        end
        reset  = 1'b0;
        m_last = 1;
        do_op("rst_tie", 2'b11, 2'b00, 32'hD98D_4F00, 32'h4F08_0B80, 4, 1'b0, 16'h1E90, 2'b00);

        for (int i = 0; i < 30; i++) begin
            do_op("rnd", 2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
                  $urandom_range(1, 24), ($urandom_range(0, 9) == 0),
                  16'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_muldiv_arbiter.md
Name: fpu_muldiv_arbiter

Overview:
- Shares one multi-cycle half-precision multiply/divide unit (mulDivCircuit) between two requesters.
- Round-robin arbitration; captures and holds operands; issues the unit's one-cycle start pulse (drives the unit's reset input); waits for done; returns the result and OFUF flags to the granted requester.
- Timeout watchdog so a hung unit cannot stall both requesters.
- Sits between FPU issue logic and mulDivCircuit.

Parameters:
- TIMEOUT, 64: max WAIT cycles before forcing a timeout response (>=2).
- CNT_W, $clog2(TIMEOUT+1): watchdog counter width.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  per-requester request; bit i = requester i.
- op  input  2  per-requester operation; 0 = mul, 1 = div.
- x_in  input  32  operand X, {x1,x0}, 16 bits each.
- y_in  input  32  operand Y, {y1,y0}.
- gnt  output  2  one-hot grant; high for exactly one cycle in START.
- rsp_valid  output  2  one-hot response strobe; high one cycle in RESP.
- rsp_result  output  16  result for the rsp_valid requester.
- rsp_ofuf  output  2  unit OFUF for the response.
- rsp_timeout  output  1  response was forced by the watchdog.
- busy  output  1  high in any state other than IDLE.
- unit_x  output  16  held operand X to the unit.
- unit_y  output  16  held operand Y.
- unit_muldiv  output  1  held op to the unit.
- unit_start  output  1  one-cycle start pulse; wired to the unit's reset input.
- unit_done  input  1  unit done.
- unit_result  input  16  unit result.
- unit_ofuf  input  2  unit overflow/underflow flags.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0: gnt, rsp_*, busy, unit_x/y/muldiv, unit_start.
  - Watchdog = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Reset mid-operation abandons the operation; no rsp_valid is produced. The unit is not reset by this block's reset; the next START re-initialises it.
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req bit set: grant it.
  - Both req bits set: grant index != last.
  - On grant, at the clock edge: latch x/y/op of the winner into unit_x/unit_y/unit_muldiv; set last = winner; go to START.
- START (exactly 1 cycle):
  - unit_start = 1, gnt[winner] = 1, watchdog cleared.
  - unit_done is ignored in this cycle, even if still high from the previous op.
  - Next state: WAIT.
- WAIT:
  - unit_start = 0; unit_done sampled every cycle.
  - unit_done = 1: capture unit_result/unit_ofuf into rsp_result/rsp_ofuf; rsp_timeout = 0; go to RESP.
  - Otherwise increment watchdog. When watchdog == TIMEOUT-1 and done is still low: rsp_result = 0x0000, rsp_ofuf = 00, rsp_timeout = 1; go to RESP.
  - Done takes priority over timeout when both occur in the same cycle.
- RESP (exactly 1 cycle):
  - rsp_valid[winner] = 1.
  - rsp_result/rsp_ofuf/rsp_timeout are valid in this cycle and held until the next RESP.
  - Next state: IDLE.
- Handshake rules:
  - A requester holds req, op and operands stable until it sees gnt.
  - After gnt it may change operands freely.
  - It may keep req high to queue another op.
  - req is sampled only in IDLE.
- Hold rule: unit_x/unit_y/unit_muldiv stay constant from capture until the next grant, including through IDLE.
- Latency: req to gnt is 1 cycle. Response is in the cycle after the first WAIT cycle with unit_done = 1. Minimum request-to-rsp_valid is 4 cycles (IDLE, START, WAIT, RESP).
- Fairness: with both requesters continuously requesting, grants strictly alternate; each waits at most one full operation.
- busy = 1 in START, WAIT and RESP.

Test Plan:
- Single mul: bench model of the unit raises done 8 cycles after start with result 0x1E90, OFUF 00; stimulus req=01, x0=4F00, y0=0B80, op0=0.
  - Expect gnt=01 one cycle, unit_start one pulse, unit_x=4F00, unit_y=0B80, unit_muldiv=0.
  - Expect rsp_valid=01 one cycle with rsp_result=1E90, rsp_ofuf=00, rsp_timeout=0.
- Tie after reset: req=11; x0=4F00/y0=0B80; x1=D98D/y1=4F08; op=00; model returns 1E90 and ECE0.
  - First gnt=01, rsp_valid=01 with 1E90; then gnt=10, rsp_valid=10 with ECE0.
  - A third tie grants 01 again.
- Stale done: model holds unit_done=1 from the previous op until unit_start, then low for 5 cycles, then high with 0x1234.
  - No response during START.
  - rsp_result=1234 arrives only after the new done.
- Timeout: model never asserts done; TIMEOUT=64; div request on requester 1.
  - rsp_valid=10, rsp_timeout=1, rsp_result=0000 exactly 64 cycles after entering WAIT.
  - A following request gets a fresh unit_start and completes normally with rsp_timeout=0.
- Reset mid-WAIT: assert reset 3 cycles into WAIT.
  - All outputs 0 immediately (asynchronous), no rsp_valid.
  - After release, req=11 grants requester 0 first.
- Done/timeout coincidence: unit_done rises exactly when watchdog == TIMEOUT-1.
  - Response carries the unit result with rsp_timeout=0.
